// File: rtl/bsg_scoreboard_id_arbiter.sv
// bsg_scoreboard_id_arbiter
// Shares a pool of els_p IDs among num_reqs_p requesters. It grants at most one ID per cycle.
// Requesters are chosen round-robin. Each grant takes the lowest free ID.
// The block tracks which requester owns each ID and how many IDs each requester holds.
// Each requester may hold at most max_out_p IDs at once.
// A drain FSM blocks new grants so that software can empty the pool.
module bsg_scoreboard_id_arbiter #(
    parameter int els_p      = 8,
    parameter int num_reqs_p = 4,
    parameter int max_out_p  = 4,
    localparam int id_w  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int own_w = (num_reqs_p > 1) ? $clog2(num_reqs_p) : 1,
    localparam int cnt_w = (max_out_p + 1 > 1) ? $clog2(max_out_p + 1) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [num_reqs_p-1:0]       req_v_i,
    output logic [num_reqs_p-1:0]       req_yumi_o,
    output logic [id_w-1:0]             grant_id_o,
    input  logic                        free_v_i,
    input  logic [id_w-1:0]             free_id_i,
    input  logic                        drain_i,
    output logic                        drained_o,
    output logic [els_p-1:0]            scoreboard_r_o,
    output logic [num_reqs_p*cnt_w-1:0] out_cnt_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam logic [1:0] st_run     = 2'd0;
    localparam logic [1:0] st_drain   = 2'd1;
    localparam logic [1:0] st_drained = 2'd2;

    logic [els_p-1:0]      scoreboard_r;
    logic [own_w-1:0]      owner_r [els_p];
    logic [cnt_w-1:0]      cnt_r   [num_reqs_p];
    logic [own_w-1:0]      ptr_r;
    logic [1:0]            state_r;
    logic [1:0]            state_n;

    logic                  full;
    logic                  empty;
    logic                  grants_en;
    logic [num_reqs_p-1:0] eligible;
    logic                  found;
    logic [own_w-1:0]      winner;
    logic                  id_found;
    logic [id_w-1:0]       grant_id;
    logic                  free_ok;
    logic [own_w-1:0]      free_owner;
    int                    idx;

    assign full  = &scoreboard_r;
    assign empty = ~|scoreboard_r;

    // A grant may happen only while running, with no drain request and reset released.
    assign grants_en = reset_n_i && (state_r == st_run) && !drain_i;

    // Find which requesters may win this cycle.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        eligible = '0;
        for (int k = 0; k < num_reqs_p; k++) begin
            eligible[k] = req_v_i[k] && (cnt_r[k] < cnt_w'(max_out_p)) && !full && grants_en;
        end
    end

    // Round-robin search: take the first eligible requester at or after ptr_r, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < num_reqs_p; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= num_reqs_p) idx = idx - num_reqs_p;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = own_w'(idx);
            end
        end
    end

    // Grant the lowest-index free ID. Only the registered scoreboard is searched,
    // so an ID freed this cycle cannot be granted again until the next cycle.
    always_comb begin
        id_found = 1'b0;
        grant_id = '0;
        for (int i = 0; i < els_p; i++) begin
            if (!id_found && !scoreboard_r[i]) begin
                id_found = 1'b1;
                grant_id = id_w'(i);
            end
        end
    end

    // Drive the one-hot grant toward the winning requester.
    always_comb begin
        req_yumi_o = '0;
        if (found) req_yumi_o[winner] = 1'b1;
    end

    assign grant_id_o = grant_id;

    // A free is honoured only for an ID that is currently allocated.
    assign free_ok    = free_v_i && scoreboard_r[free_id_i];
    assign free_owner = owner_r[free_id_i];

    // Set the bit for a granted ID and clear the bit for a freed ID.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!reset_n_i) begin
            scoreboard_r <= '0;
        end else begin
            if (found)   scoreboard_r[grant_id]  <= 1'b1;
            if (free_ok) scoreboard_r[free_id_i] <= 1'b0;
        end
    end

    // Record which requester owns each granted ID.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: the owner table is a small register array, and it is reset so that it starts at a known value.
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) owner_r[i] <= '0;
        end else if (found) begin
            owner_r[grant_id] <= winner;
        end
    end

    // Count the IDs each requester holds. A grant and a free on the same requester cancel out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < num_reqs_p; k++) cnt_r[k] <= '0;
        end else begin
            for (int k = 0; k < num_reqs_p; k++) begin
                if ((found && winner == own_w'(k)) && !(free_ok && free_owner == own_w'(k)))
                    cnt_r[k] <= cnt_r[k] + cnt_w'(1);
                else if (!(found && winner == own_w'(k)) && (free_ok && free_owner == own_w'(k)))
                    cnt_r[k] <= cnt_r[k] - cnt_w'(1);
            end
        end
    end

    // After a grant, the round-robin pointer moves to the requester after the winner.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (found) begin
            ptr_r <= (winner == own_w'(num_reqs_p - 1)) ? '0 : winner + own_w'(1);
        end
    end

    // Next-state logic for the drain FSM.
    always_comb begin
        state_n = state_r;
        case (state_r)
            st_run:     if (drain_i) state_n = st_drain;
            st_drain:   if (!drain_i) state_n = st_run;
                        else if (empty) state_n = st_drained;
            st_drained: if (!drain_i) state_n = st_run;
            default:    state_n = st_run;
        endcase
    end

    // State register for the drain FSM.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= st_run;
        else            state_r <= state_n;
    end

    // Pack the per-requester counts onto the flat output bus.
    always_comb begin
        out_cnt_o = '0;
        for (int k = 0; k < num_reqs_p; k++) out_cnt_o[k*cnt_w +: cnt_w] = cnt_r[k];
    end

    assign drained_o      = (state_r == st_drained);
    assign scoreboard_r_o = scoreboard_r;
    assign full_o         = full;
    assign empty_o        = empty;

    // Freeing an ID that is not allocated is a caller error.
    free_of_allocated_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        free_v_i |-> scoreboard_r[free_id_i]);

endmodule
